// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/local-road traffic light controller and
// its upstream stages. Light codes are one-hot; anything else is treated as
// "not that colour" by every consumer.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b100;

    // Exact match only: illegal codes (e.g. 3'b110) are never green.
    function automatic logic is_green(input logic [2:0] light);
        return light == LIGHT_GREEN;
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer. The debounced level
// flips only after the synchronised input has disagreed with it for DEB_CYC
// consecutive cycles. `rise` is combinational and marks the edge on which the
// debounced level goes 0->1, so a consumer registering it lines up with `level`.
module sensor_debouncer #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    // A one-cycle debounce still needs a one-bit counter to keep the logic regular.
    localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

    logic          sync1_q,   sync1_d;
    logic          sync2_q,   sync2_d;
    logic          deb_q,     deb_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;

    // Synchroniser shift and debounce counter next-state.
    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        if (sync2_q == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_d     = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // State registers; reset drops any pending debounce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = deb_q;
    assign rise  = deb_d & ~deb_q;

endmodule

// File: rtl/lr_car_detector.sv
// Local-road car detector: counts debounced arrivals on the loop sensor and
// retires one waiting car every DEPART_CYC cycles of local-road Green.
// Control lives entirely in the departure timer, the car counter and the
// debounced sensor level; there is no separate state machine.
module lr_car_detector
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned DEPART_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic [CNT_W-1:0] car_count,
    output logic             arrive_pulse
);

    localparam int unsigned DW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
    localparam logic [DW-1:0]    DEP_LAST = DW'(DEPART_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             arrive;
    logic             sensor_level;
    logic             green;
    logic             depart;

    logic [DW-1:0]    dep_cnt_q,      dep_cnt_d;
    logic [CNT_W-1:0] car_count_q,    car_count_d;
    logic             arrive_pulse_q, arrive_pulse_d;

    sensor_debouncer #(
        .DEB_CYC (DEB_CYC)
    ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sensor_raw),
        .level (sensor_level),
        .rise  (arrive)
    );

    // Departure timer: runs only while Green with cars waiting, so it starts
    // fresh on every Green phase and whenever the queue empties.
    always_comb begin
        green     = is_green(lr_light);
        depart    = 1'b0;
        dep_cnt_d = '0;
        if (green && (car_count_q != '0)) begin
            if (dep_cnt_q == DEP_LAST) begin
                depart    = 1'b1;
                dep_cnt_d = '0;
            end else begin
                dep_cnt_d = dep_cnt_q + 1'b1;
            end
        end
    end

    // Car counter: arrival and departure on the same edge cancel; arrivals
    // beyond the counter's range are dropped.
    always_comb begin
        car_count_d    = car_count_q;
        arrive_pulse_d = arrive;
        case ({arrive, depart})
            2'b10: begin
                if (car_count_q != CNT_MAX) begin
                    car_count_d = car_count_q + 1'b1;
                end
            end
            2'b01:   car_count_d = car_count_q - 1'b1;
            default: car_count_d = car_count_q;
        endcase
    end

    // State registers; reset discards any pending departure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dep_cnt_q      <= '0;
            car_count_q    <= '0;
            arrive_pulse_q <= 1'b0;
        end else begin
            dep_cnt_q      <= dep_cnt_d;
            car_count_q    <= car_count_d;
            arrive_pulse_q <= arrive_pulse_d;
        end
    end

    assign lr_has_car   = (car_count_q != '0);
    assign car_count    = car_count_q;
    assign arrive_pulse = arrive_pulse_q;

    // The debounced level itself is not needed downstream; arrivals come from `rise`.
    logic unused_level;
    assign unused_level = sensor_level;

endmodule

// File: tb/tb_lr_car_detector.sv
// Bench for lr_car_detector: directed scenarios plus random traffic, with a
// per-cycle reference model feeding an expected queue and a monitor comparing.
module tb_lr_car_detector;
    import traffic_pkg::*;

    localparam int DEB_CYC    = 4;
    localparam int CNT_W      = 4;
    localparam int DEPART_CYC = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             sensor_raw;
    logic [2:0]       lr_light;
    logic             lr_has_car;
    logic [CNT_W-1:0] car_count;
    logic             arrive_pulse;

    always #5 clk = ~clk;

    lr_car_detector #(
        .DEB_CYC    (DEB_CYC),
        .CNT_W      (CNT_W),
        .DEPART_CYC (DEPART_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_raw   (sensor_raw),
        .lr_light     (lr_light),
        .lr_has_car   (lr_has_car),
        .car_count    (car_count),
        .arrive_pulse (arrive_pulse)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {lr_has_car, arrive_pulse, car_count}
    logic [CNT_W+1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sync2 is the raw value seen two edges earlier; the
    // debounced level flips once the last DEB_CYC synced samples all disagree
    // with it; departures happen every DEPART_CYC-th consecutive Green edge
    // with cars waiting.
    initial begin : ref_model
        bit raw_hist[$];
        bit win[$];
        bit level;
        bit arrive;
        bit depart;
        bit s;
        bit all_diff;
        int green_run;
        int cnt;
        logic [CNT_W+1:0] e;
        level = 0; green_run = 0; cnt = 0;
        forever begin
            @(posedge clk);
            arrive = 0;
            depart = 0;
            if (!rst_n) begin
                raw_hist.delete();
                win.delete();
                level     = 0;
                green_run = 0;
                cnt       = 0;
            end else begin
                s = (raw_hist.size() == 2) ? raw_hist[0] : 1'b0;
                raw_hist.push_back(sensor_raw);
                if (raw_hist.size() > 2) void'(raw_hist.pop_front());
                win.push_back(s);
                if (win.size() > DEB_CYC) void'(win.pop_front());
                all_diff = (win.size() == DEB_CYC);
                foreach (win[i]) if (win[i] == level) all_diff = 0;
                if (all_diff) begin
                    level  = ~level;
                    arrive = level;
                    win.delete();
                end
                if (lr_light == LIGHT_GREEN && cnt != 0) begin
                    green_run++;
                    if (green_run == DEPART_CYC) begin
                        depart    = 1;
                        green_run = 0;
                    end
                end else begin
                    green_run = 0;
                end
                if (arrive && !depart) begin
                    if (cnt < CNT_MAX) cnt++;
                end else if (depart && !arrive) begin
                    cnt--;
                end
            end
            e = {(cnt != 0), arrive, cnt[CNT_W-1:0]};
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle the DUT presents a fresh output set.
    initial begin : monitor
        logic [CNT_W+1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("car_count",    int'(car_count),    int'(e[CNT_W-1:0]));
                check("arrive_pulse", int'(arrive_pulse), int'(e[CNT_W]));
                check("lr_has_car",   int'(lr_has_car),   int'(e[CNT_W+1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        sensor_raw = 1'b0;
        rst_n      = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic car(input int hi, input int lo);
        sensor_raw = 1'b1;
        tick(hi);
        sensor_raw = 1'b0;
        tick(lo);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int got;
        int r;
        rst_n      = 1'b0;
        sensor_raw = 1'b1;
        lr_light   = LIGHT_RED;

        // 1: reset with sensor held high, arrival latency after release
        tick(3);
        check("reset_count", int'(car_count), 0);
        check("reset_has_car", int'(lr_has_car), 0);
        rst_n = 1'b1;
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (arrive_pulse && got == 0) got = i;
        end
        check("arrival_latency", got, DEB_CYC + 2);
        check("s1_count", int'(car_count), 1);
        check("s1_has_car", int'(lr_has_car), 1);

        // 2: glitch rejected, full-length pulse accepted
        do_reset();
        car(3, 10);
        check("glitch_count", int'(car_count), 0);
        car(4, 10);
        check("min_pulse_count", int'(car_count), 1);

        // 3: two arrivals, then continuous Green drains them
        do_reset();
        car(10, 10);
        car(10, 10);
        check("two_cars", int'(car_count), 2);
        lr_light = LIGHT_GREEN;
        tick(DEPART_CYC);
        check("drain_first", int'(car_count), 1);
        tick(DEPART_CYC);
        check("drain_second", int'(car_count), 0);
        check("drain_has_car", int'(lr_has_car), 0);

        // 4: Green interrupted by Yellow restarts the departure timer
        lr_light = LIGHT_RED;
        do_reset();
        car(10, 10);
        car(10, 10);
        car(10, 10);
        lr_light = LIGHT_GREEN;
        tick(5);
        check("partial_green", int'(car_count), 3);
        lr_light = LIGHT_YELLOW;
        tick(3);
        lr_light = LIGHT_GREEN;
        tick(DEPART_CYC - 1);
        check("resume_no_depart", int'(car_count), 3);
        tick(1);
        check("resume_depart", int'(car_count), 2);

        // 5: arrival and departure on the same edge
        lr_light = LIGHT_RED;
        do_reset();
        car(10, 10);
        lr_light = LIGHT_GREEN;
        tick(2);
        sensor_raw = 1'b1;
        tick(6);
        check("simul_pulse", int'(arrive_pulse), 1);
        check("simul_count", int'(car_count), 1);
        sensor_raw = 1'b0;
        tick(12);

        // 6: saturation, then reset mid-debounce
        lr_light = LIGHT_RED;
        do_reset();
        for (int i = 0; i < CNT_MAX; i++) car(8, 8);
        check("near_sat", int'(car_count), CNT_MAX);
        sensor_raw = 1'b1;
        tick(DEB_CYC + 2);
        check("sat_pulse", int'(arrive_pulse), 1);
        check("sat_count", int'(car_count), CNT_MAX);
        sensor_raw = 1'b0;
        tick(8);
        sensor_raw = 1'b1;
        tick(4);
        rst_n      = 1'b0;
        sensor_raw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(12);
        check("reset_mid_deb", int'(car_count), 0);

        // Random traffic, including illegal light codes and occasional resets
        for (int i = 0; i < 400; i++) begin
            sensor_raw = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 4)      lr_light = LIGHT_GREEN;
            else if (r < 6) lr_light = LIGHT_RED;
            else if (r < 8) lr_light = LIGHT_YELLOW;
            else            lr_light = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 99) != 0);
            tick($urandom_range(1, 10));
            rst_n = 1'b1;
        end

        tick(2);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
